// File: rtl/otter_hazard_ctrl_if.sv
// Hazard controller bus: ID-stage metadata and redirect/interrupt requests in,
// pipeline register enables, forwarding selects, trap pulse and perf counters out.
// Ports (all signals):
//   ID_VALID, ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, ID_RD, ID_REG_WRITE,
//   ID_IS_LOAD, EX_REDIRECT, INTR               : pipeline -> controller
//   PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE, FWD_A_SEL, FWD_B_SEL,
//   TRAP_TAKE, STALL_CNT, FLUSH_CNT             : controller -> pipeline
// Modports: master = pipeline side, slave = controller side.
interface otter_hazard_ctrl_if #(
    parameter int unsigned NSTAGES = 3,
    parameter int unsigned RA_W    = 5,
    parameter int unsigned CNT_W   = 16
);
    localparam int unsigned FWD_W = $clog2(NSTAGES);

    logic             ID_VALID;
    logic [RA_W-1:0]  ID_RS1;
    logic [RA_W-1:0]  ID_RS2;
    logic             ID_USES_RS1;
    logic             ID_USES_RS2;
    logic [RA_W-1:0]  ID_RD;
    logic             ID_REG_WRITE;
    logic             ID_IS_LOAD;
    logic             EX_REDIRECT;
    logic             INTR;

    logic             PC_WRITE;
    logic             IF_ID_WRITE;
    logic             IF_ID_FLUSH;
    logic             ID_EX_BUBBLE;
    logic [FWD_W-1:0] FWD_A_SEL;
    logic [FWD_W-1:0] FWD_B_SEL;
    logic             TRAP_TAKE;
    logic [CNT_W-1:0] STALL_CNT;
    logic [CNT_W-1:0] FLUSH_CNT;

    modport master (
        output ID_VALID, ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
               ID_RD, ID_REG_WRITE, ID_IS_LOAD, EX_REDIRECT, INTR,
        input  PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE,
               FWD_A_SEL, FWD_B_SEL, TRAP_TAKE, STALL_CNT, FLUSH_CNT
    );

    modport slave (
        input  ID_VALID, ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
               ID_RD, ID_REG_WRITE, ID_IS_LOAD, EX_REDIRECT, INTR,
        output PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE,
               FWD_A_SEL, FWD_B_SEL, TRAP_TAKE, STALL_CNT, FLUSH_CNT
    );
endinterface

// File: rtl/otter_hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the pipelined OTTER core.
// Tracks post-decode instructions in a shifting scoreboard (slot 0 = EX ...
// slot NSTAGES-1 = WB) and derives PC/IF-ID enables, load-use stalls,
// redirect flushes, EX forwarding selects and a drain-then-trap interrupt
// sequence. Saturating stall/flush event counters are kept for profiling.
// Ports:
//   CLK    : clock, rising edge
//   RST_N  : asynchronous active-low reset
//   bus    : otter_hazard_ctrl_if slave modport (see interface header)
module otter_hazard_ctrl #(
    parameter int unsigned NSTAGES  = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned RA_W     = 5,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    otter_hazard_ctrl_if.slave bus
);
    localparam int unsigned FWD_W  = $clog2(NSTAGES);
    localparam int unsigned DCNT_W = 3;

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, TRAP = 2'd2} state_t;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            reg_write;
        logic            is_load;
    } slot_t;

    state_t            state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    slot_t             slot_q [NSTAGES];
    logic [RA_W-1:0]   ex_rs1_q, ex_rs2_q;
    logic              ex_uses_rs1_q, ex_uses_rs2_q;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    logic              pc_write, if_id_write, if_id_flush, id_ex_bubble, trap_take;
    logic              load_use, stall_evt, issue;
    logic [FWD_W-1:0]  fwd_a, fwd_b;

    // A slot produces rs when it writes it back; x0 is never a dependency.
    function automatic logic match(input slot_t s, input logic [RA_W-1:0] rs);
        return s.valid && s.reg_write && (s.rd == rs) && (rs != '0);
    endfunction

    // Load-use hazard: ID consumes a load result not yet forwardable.
    always_comb begin
        load_use = 1'b0;
        for (int j = 0; j < int'(LOAD_LAT); j++) begin
            if (slot_q[j].is_load) begin
                if (bus.ID_USES_RS1 && match(slot_q[j], bus.ID_RS1)) load_use = 1'b1;
                if (bus.ID_USES_RS2 && match(slot_q[j], bus.ID_RS2)) load_use = 1'b1;
            end
        end
        load_use = load_use && bus.ID_VALID;
    end

    // Forwarding selects; scanning oldest-first lets the youngest producer win.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = int'(NSTAGES) - 1; k >= 1; k--) begin
            if (slot_q[0].valid && ex_uses_rs1_q && match(slot_q[k], ex_rs1_q)) fwd_a = FWD_W'(k);
            if (slot_q[0].valid && ex_uses_rs2_q && match(slot_q[k], ex_rs2_q)) fwd_b = FWD_W'(k);
        end
    end

    // Next-state and control outputs, highest priority last-overriding via case order.
    always_comb begin
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        trap_take    = 1'b0;
        stall_evt    = 1'b0;
        unique case (state_q)
            TRAP: begin
                trap_take    = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                state_d      = RUN;
            end
            DRAIN: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                // Counter holds the drain cycles still owed including this one.
                if (dcnt_q <= DCNT_W'(1)) state_d = TRAP;
                else                      dcnt_d  = dcnt_q - DCNT_W'(1);
            end
            default: begin
                if (bus.EX_REDIRECT) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (bus.INTR) begin
                    // Hold the ID instruction as the MEPC target while the pipe drains.
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_d      = DRAIN;
                    dcnt_d       = DCNT_W'(NSTAGES - 1);
                end else if (load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    stall_evt    = 1'b1;
                end
            end
        endcase
        if (!RST_N) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            trap_take    = 1'b0;
            stall_evt    = 1'b0;
            state_d      = RUN;
        end
    end

    assign issue = bus.ID_VALID && !id_ex_bubble;

    // FSM state and drain counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= RUN;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Scoreboard shift; slot 0 takes the issuing ID instruction or a bubble.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(NSTAGES); i++) slot_q[i] <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_uses_rs1_q <= 1'b0;
            ex_uses_rs2_q <= 1'b0;
        end else begin
            for (int i = 1; i < int'(NSTAGES); i++) slot_q[i] <= slot_q[i-1];
            slot_q[0]     <= issue ? slot_t'{valid: 1'b1, rd: bus.ID_RD,
                                             reg_write: bus.ID_REG_WRITE,
                                             is_load: bus.ID_IS_LOAD} : '0;
            ex_rs1_q      <= issue ? bus.ID_RS1 : '0;
            ex_rs2_q      <= issue ? bus.ID_RS2 : '0;
            ex_uses_rs1_q <= issue && bus.ID_USES_RS1;
            ex_uses_rs2_q <= issue && bus.ID_USES_RS2;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_evt && (stall_cnt_q != '1))   stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (if_id_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.PC_WRITE     = pc_write;
    assign bus.IF_ID_WRITE  = if_id_write;
    assign bus.IF_ID_FLUSH  = if_id_flush;
    assign bus.ID_EX_BUBBLE = id_ex_bubble;
    assign bus.TRAP_TAKE    = trap_take;
    assign bus.FWD_A_SEL    = RST_N ? fwd_a : '0;
    assign bus.FWD_B_SEL    = RST_N ? fwd_b : '0;
    assign bus.STALL_CNT    = stall_cnt_q;
    assign bus.FLUSH_CNT    = flush_cnt_q;
endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Directed self-checking bench for otter_hazard_ctrl (NSTAGES=3, LOAD_LAT=1,
// CNT_W=2 so counter saturation is reachable). Inputs change 1 time unit
// after the rising edge; outputs are checked 2 units after the edge.
module tb_otter_hazard_ctrl;
    logic CLK;
    logic RST_N;
    int   n_chk;
    int   n_pass;

    otter_hazard_ctrl_if #(.NSTAGES(3), .RA_W(5), .CNT_W(2)) bus ();

    otter_hazard_ctrl #(.NSTAGES(3), .LOAD_LAT(1), .RA_W(5), .CNT_W(2)) u_dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic id_set(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic ld);
        bus.ID_VALID     = v;
        bus.ID_RS1       = rs1;
        bus.ID_RS2       = rs2;
        bus.ID_USES_RS1  = u1;
        bus.ID_USES_RS2  = u2;
        bus.ID_RD        = rd;
        bus.ID_REG_WRITE = rw;
        bus.ID_IS_LOAD   = ld;
    endtask

    task automatic id_nop();
        id_set(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Control outputs as {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE, TRAP_TAKE}.
    function automatic logic [4:0] ctl();
        return {bus.PC_WRITE, bus.IF_ID_WRITE, bus.IF_ID_FLUSH, bus.ID_EX_BUBBLE, bus.TRAP_TAKE};
    endfunction

    initial begin
        n_chk  = 0;
        n_pass = 0;
        RST_N  = 1'b0;
        bus.EX_REDIRECT = 1'b0;
        bus.INTR        = 1'b0;
        id_nop();

        // Reset state
        #2;
        chk("rst_ctl", 32'(ctl()), 32'(5'b00110));
        chk("rst_fwd_a", 32'(bus.FWD_A_SEL), 0);
        chk("rst_fwd_b", 32'(bus.FWD_B_SEL), 0);
        chk("rst_cnts", {bus.STALL_CNT, bus.FLUSH_CNT}, 0);
        tick();
        tick();
        RST_N = 1'b1;
        #1;
        chk("run_idle_ctl", 32'(ctl()), 32'(5'b11000));

        // add x5,x1,x2 ; sub x6,x5,x3 -> forward from slot 1
        tick(); id_set(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0); #1;
        tick(); id_set(1, 5'd5, 5'd3, 1, 1, 5'd6, 1, 0); #1;
        chk("alu_dep_nostall", 32'(ctl()), 32'(5'b11000));
        tick(); id_nop(); #1;
        chk("fwd_a_slot1", 32'(bus.FWD_A_SEL), 1);
        chk("fwd_b_none", 32'(bus.FWD_B_SEL), 0);

        // add x5 ; nop ; sub x6,x5,x3 -> forward from slot 2
        tick(); id_set(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0); #1;
        tick(); id_nop(); #1;
        tick(); id_set(1, 5'd5, 5'd3, 1, 1, 5'd6, 1, 0); #1;
        tick(); id_nop(); #1;
        chk("fwd_a_slot2", 32'(bus.FWD_A_SEL), 2);

        // Two producers of x5 back to back -> youngest (slot 1) wins on both operands
        tick(); id_set(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0); #1;
        tick(); id_set(1, 5'd1, 5'd1, 1, 1, 5'd5, 1, 0); #1;
        tick(); id_set(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0); #1;
        tick(); id_nop(); #1;
        chk("fwd_young_a", 32'(bus.FWD_A_SEL), 1);
        chk("fwd_young_b", 32'(bus.FWD_B_SEL), 1);
        tick(); tick(); tick();

        // lw x6,0(x1) ; add x7,x6,x1 -> one stall cycle then forward from slot 2
        id_set(1, 5'd1, 5'd0, 1, 0, 5'd6, 1, 1); #1;
        chk("lw_issue", 32'(ctl()), 32'(5'b11000));
        tick(); id_set(1, 5'd6, 5'd1, 1, 1, 5'd7, 1, 0); #1;
        chk("lu_stall", 32'(ctl()), 32'(5'b00010));
        tick(); #1;
        chk("lu_release", 32'(ctl()), 32'(5'b11000));
        chk("lu_stall_cnt", 32'(bus.STALL_CNT), 1);
        tick(); id_nop(); #1;
        chk("lu_fwd_a", 32'(bus.FWD_A_SEL), 2);
        chk("lu_fwd_b", 32'(bus.FWD_B_SEL), 0);

        // Load to x0 then consumer of x0 -> no stall, no forwarding
        tick(); id_set(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1); #1;
        tick(); id_set(1, 5'd0, 5'd0, 1, 1, 5'd8, 1, 0); #1;
        chk("x0_nostall", 32'(ctl()), 32'(5'b11000));
        tick(); id_nop(); #1;
        chk("x0_fwd", 32'({bus.FWD_A_SEL, bus.FWD_B_SEL}), 0);

        // Redirect while ID holds a load-use consumer -> flush wins, no stall counted
        tick(); id_set(1, 5'd1, 5'd0, 1, 0, 5'd6, 1, 1); #1;
        tick(); id_set(1, 5'd6, 5'd1, 1, 1, 5'd7, 1, 0); bus.EX_REDIRECT = 1'b1; #1;
        chk("redir_ctl", 32'(ctl()), 32'(5'b11110));
        tick(); id_nop(); bus.EX_REDIRECT = 1'b0; #1;
        chk("redir_stall_cnt", 32'(bus.STALL_CNT), 1);
        chk("redir_flush_cnt", 32'(bus.FLUSH_CNT), 1);

        // Interrupt with three valid slots: DRAIN T+1..T+2, TRAP at T+3
        tick(); id_set(1, 5'd1, 5'd2, 1, 1, 5'd10, 1, 0); #1;
        tick(); id_set(1, 5'd1, 5'd2, 1, 1, 5'd11, 1, 0); #1;
        tick(); id_set(1, 5'd1, 5'd2, 1, 1, 5'd12, 1, 0); #1;
        tick(); id_set(1, 5'd1, 5'd2, 1, 1, 5'd13, 1, 0); bus.INTR = 1'b1; #1;
        chk("intr_T", 32'(ctl()), 32'(5'b00010));
        tick(); bus.INTR = 1'b0; bus.EX_REDIRECT = 1'b1; #1;
        chk("intr_T1_drain", 32'(ctl()), 32'(5'b00010));
        tick(); bus.EX_REDIRECT = 1'b0; #1;
        chk("intr_T2_drain", 32'(ctl()), 32'(5'b00010));
        tick(); #1;
        chk("intr_T3_trap", 32'(ctl()), 32'(5'b11111));
        chk("intr_T3_fwd", 32'({bus.FWD_A_SEL, bus.FWD_B_SEL}), 0);
        tick(); id_nop(); #1;
        chk("intr_T4_run", 32'(ctl()), 32'(5'b11000));
        chk("intr_flush_cnt", 32'(bus.FLUSH_CNT), 2);

        // INTR together with EX_REDIRECT -> redirect taken, interrupt not accepted
        tick(); bus.INTR = 1'b1; bus.EX_REDIRECT = 1'b1; #1;
        chk("intr_redir_ctl", 32'(ctl()), 32'(5'b11110));
        tick(); bus.INTR = 1'b0; bus.EX_REDIRECT = 1'b0; #1;
        chk("intr_redir_run", 32'(ctl()), 32'(5'b11000));
        chk("flush_cnt_3", 32'(bus.FLUSH_CNT), 3);

        // Reset, then five redirects -> 2-bit flush counter saturates at 3
        RST_N = 1'b0; #1;
        chk("rst2_cnts", {bus.STALL_CNT, bus.FLUSH_CNT}, 0);
        tick(); RST_N = 1'b1;
        for (int r = 0; r < 5; r++) begin
            tick(); bus.EX_REDIRECT = 1'b1; #1;
            if (r == 2) chk("sat_cnt_2", 32'(bus.FLUSH_CNT), 2);
        end
        tick(); bus.EX_REDIRECT = 1'b0; #1;
        chk("sat_cnt_3", 32'(bus.FLUSH_CNT), 3);

        // Reset during DRAIN abandons the trap
        tick(); bus.INTR = 1'b1; #1;
        tick(); bus.INTR = 1'b0; #1;
        chk("rst_drain_pre", 32'(ctl()), 32'(5'b00010));
        RST_N = 1'b0; #1;
        chk("rst_drain_ctl", 32'(ctl()), 32'(5'b00110));
        chk("rst_drain_cnts", {bus.STALL_CNT, bus.FLUSH_CNT}, 0);
        tick(); tick(); RST_N = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(); #1;
            chk("rst_drain_run", 32'(ctl()), 32'(5'b11000));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/otter_hazard_ctrl.md
# otter_hazard_ctrl

Parametrised pipeline hazard and sequencing controller for the pipelined OTTER core. It sits beside the IF/ID/EX/MEM/WB pipeline registers and owns everything the current pipeline lacks: the PC/IF-ID write enables, load-use stalls, branch/jump flushes, EX-stage forwarding selects, and a drain-then-trap interrupt sequence. It also provides saturating stall and flush performance counters. Instruction metadata is tracked in an internal scoreboard whose depth is set by `NSTAGES`.

## Interface
- `NSTAGES`, default 3: tracked post-decode slots; slot 0 = EX, slot 1 = MEM, …, slot `NSTAGES-1` = WB. Legal range 2..6.
- `LOAD_LAT`, default 1: a load in slot j < `LOAD_LAT` cannot yet be forwarded. Legal range 1..`NSTAGES-1`.
- `RA_W`, default 5: register address width.
- `CNT_W`, default 16: performance counter width.
- `CLK` in 1: the single clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `ID_VALID` in 1: the IF/ID register holds a real instruction.
- `ID_RS1`, `ID_RS2` in `RA_W`: source registers of the ID instruction.
- `ID_USES_RS1`, `ID_USES_RS2` in 1: the ID instruction reads that source.
- `ID_RD` in `RA_W`; `ID_REG_WRITE` in 1; `ID_IS_LOAD` in 1: destination metadata of the ID instruction.
- `EX_REDIRECT` in 1: the instruction in EX resolved a taken branch, jal, jalr or mret this cycle.
- `INTR` in 1: interrupt request, already masked by MSTATUS.MIE.
- `PC_WRITE` out 1: PC load enable.
- `IF_ID_WRITE` out 1: IF/ID register load enable.
- `IF_ID_FLUSH` out 1: clears IF/ID to a NOP on the next edge.
- `ID_EX_BUBBLE` out 1: loads a NOP into ID/EX instead of the ID instruction.
- `FWD_A_SEL`, `FWD_B_SEL` out `$clog2(NSTAGES)`: EX operand source. 0 = ID/EX register data; k = result held at the output of slot k.
- `TRAP_TAKE` out 1: one-cycle pulse. CSR saves the held IF/ID PC to MEPC, the PC mux selects MTVEC.
- `STALL_CNT`, `FLUSH_CNT` out `CNT_W`: saturating event counters.

## Operation
- **Scoreboard.** Each slot holds {valid, rd, reg_write, is_load}. Slot 0 also holds rs1/rs2 and their use flags.
  - Every edge, slot i ← slot i-1.
  - Slot 0 ← the ID metadata when the ID instruction issues (`ID_VALID` & !`ID_EX_BUBBLE`); otherwise slot 0 ← invalid.
  - There is no back-pressure; slots always advance.
- **Match(slot, rs).** True when slot valid & reg_write & rd == rs & rs != 0. rd = x0 never matches.
- **Forwarding (combinational from slot 0).** `FWD_A_SEL` = the smallest k in 1..`NSTAGES-1` with Match(slot k, slot0.rs1) & slot0.uses_rs1; otherwise 0. `FWD_B_SEL` is the same for rs2. The youngest producer wins.
- **Load-use stall.** Asserted when `ID_VALID` and the ID instruction uses an rs that matches a slot j < `LOAD_LAT` with is_load. Effect: `PC_WRITE`=0, `IF_ID_WRITE`=0, `ID_EX_BUBBLE`=1.
- **ID read of a register written back the same cycle.** Resolved by the register file's write-first bypass. This block does not handle it.
- **Redirect** (`EX_REDIRECT` in RUN): `PC_WRITE`=1, `IF_ID_FLUSH`=1, `ID_EX_BUBBLE`=1. No stall is applied that cycle.
- **FSM states: RUN, DRAIN, TRAP.**
  - RUN → DRAIN when `INTR` & !`EX_REDIRECT`. That cycle `PC_WRITE`=0, `IF_ID_WRITE`=0, `ID_EX_BUBBLE`=1, so the ID instruction is held as the MEPC target. The drain counter loads `NSTAGES-1`.
  - DRAIN: `PC_WRITE`=0, `IF_ID_WRITE`=0, `ID_EX_BUBBLE`=1. `EX_REDIRECT` and `INTR` are ignored. The counter decrements and the FSM moves to TRAP when it reaches 1.
  - TRAP: `TRAP_TAKE`=1, `PC_WRITE`=1, `IF_ID_FLUSH`=1, `ID_EX_BUBBLE`=1. The FSM returns to RUN.
  - An interrupt is committed once accepted; `INTR` falling during DRAIN does not abort it.
- **Priority:** reset > TRAP > DRAIN > redirect > interrupt accept > load-use stall > normal (`PC_WRITE`=`IF_ID_WRITE`=1, all other outputs 0).
- **Counters.**
  - `STALL_CNT` +1 per load-use stall cycle.
  - `FLUSH_CNT` +1 per cycle with `IF_ID_FLUSH`=1.
  - Both saturate at 2^`CNT_W`-1.

## Timing
- **Reset** (`RST_N` low, asynchronous):
  - FSM = RUN, all slots invalid, counters = 0.
  - While low: `PC_WRITE`=0, `IF_ID_WRITE`=0, `IF_ID_FLUSH`=1, `ID_EX_BUBBLE`=1, `TRAP_TAKE`=0, FWD selects = 0.
  - Reset mid-DRAIN/TRAP abandons the trap.
- **Combinational outputs.** Control outputs are combinational from registered state plus ID/`EX_REDIRECT`/`INTR` inputs in the same cycle.
- **Load-use penalty:** exactly `LOAD_LAT` cycles at the defaults (1).
- **Redirect penalty:** 2 cycles (IF/ID flushed, ID/EX bubbled).
- **Interrupt latency:** `INTR` accepted in cycle T → `TRAP_TAKE` in cycle T+`NSTAGES`. All slots are empty in the TRAP cycle.

## Test plan
- `add x5,x1,x2` then `sub x6,x5,x3` → no stall; `FWD_A_SEL`=1 while sub is in EX. With one NOP between them, `FWD_A_SEL`=2.
- `lw x6,0(x1)` then `add x7,x6,x1` → `PC_WRITE`=0 and `ID_EX_BUBBLE`=1 for exactly one cycle; then `FWD_A_SEL`=2; `STALL_CNT`=1.
- Producer with rd=x0 followed by a consumer of x0 → FWD selects stay 0, no stall.
- `EX_REDIRECT` pulsed while ID holds a load-use consumer → `IF_ID_FLUSH`=`ID_EX_BUBBLE`=`PC_WRITE`=1, `STALL_CNT` unchanged, `FLUSH_CNT` +1.
- `INTR` for 1 cycle at T with 3 valid slots (`NSTAGES`=3) → DRAIN in T+1..T+2, `TRAP_TAKE`=1 at T+3 only, IF/ID PC unchanged T..T+3; `INTR` with `EX_REDIRECT` high → not accepted that cycle.
- `CNT_W`=2 with 5 redirects → `FLUSH_CNT` saturates at 3. `RST_N` low during DRAIN → no `TRAP_TAKE`, counters 0, FSM RUN.
